// File: rtl/pc_sequencer.sv
// ---------------------------------------------------------------------------
// pc_sequencer
//
// Fetch/execute controller for the 16-bit program counter. Fetches one
// instruction from ROM, latches it into the instruction register, decodes
// the jump condition against the ALU flags and drives the PC controls so
// the PC advances exactly once per committed instruction. A fetch that
// waits too long for the ROM ends in a sticky FAULT state.
//
// Optional feature macro: PC_SEQ_HALT_DETECT_EN
//   When defined, an unconditional jump to the current PC is committed
//   without touching the PC and the sequencer parks in HALT.
//   When undefined, halted is tied 0 and such a jump executes normally.
//
// Ports:
//   clk          in   system clock, rising edge
//   reset        in   asynchronous active-low reset
//   instr        in   instruction word from ROM
//   instr_valid  in   ROM data valid (looked at only while fetch_req=1)
//   zr, ng       in   ALU zero / negative flags for the instruction in EXEC
//   a_val        in   A register value (jump target)
//   pc_out       in   current PC value
//   stall        in   datapath not ready; holds EXEC
//   fetch_req    out  instruction fetch request
//   ir           out  latched instruction register
//   exec_en      out  commit strobe to the datapath
//   pc_load      out  PC load control
//   pc_inc       out  PC increment control
//   pc_in        out  PC load value (always a_val)
//   fault        out  sticky fetch-timeout flag
//   halted       out  sticky halt flag
//   dbg_state    out  current FSM state encoding
//
// Handshake: an instruction transfers on the rising edge where
// fetch_req=1 and instr_valid=1. instr_valid at any other time is ignored,
// and the ROM may hold it low for any number of cycles (bounded by the
// timeout).
// ---------------------------------------------------------------------------
module pc_sequencer #(
    parameter int WIDTH          = 16,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] instr,
    input  logic             instr_valid,
    input  logic             zr,
    input  logic             ng,
    input  logic [WIDTH-1:0] a_val,
    input  logic [WIDTH-1:0] pc_out,
    input  logic             stall,
    output logic             fetch_req,
    output logic [WIDTH-1:0] ir,
    output logic             exec_en,
    output logic             pc_load,
    output logic             pc_inc,
    output logic [WIDTH-1:0] pc_in,
    output logic             fault,
    output logic             halted,
    output logic [2:0]       dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_EXEC  = 3'd2,
        S_FAULT = 3'd3
`ifdef PC_SEQ_HALT_DETECT_EN
        ,
        S_HALT  = 3'd4
`endif
    } state_t;

    // Counter saturates at the last legal value; reaching it while still
    // waiting is the timeout condition.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t           r_state;
    state_t           w_next_state;
    logic [WIDTH-1:0] r_ir;
    logic [7:0]       r_cnt;
    logic             w_taken;

    // Jump bits: [2]=JLT, [1]=JEQ, [0]=JGT; A-instructions never jump.
    assign w_taken = r_ir[15] & ((r_ir[2] & ng) | (r_ir[1] & zr) |
                                 (r_ir[0] & ~ng & ~zr));

`ifdef PC_SEQ_HALT_DETECT_EN
    logic w_self_jump;
    // Unconditional jump whose target is the instruction itself.
    assign w_self_jump = r_ir[15] & (r_ir[2:0] == 3'b111) & (a_val == pc_out);
`else
    logic w_unused_pc;
    assign w_unused_pc = ^pc_out;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_ir    <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next_state;
            if (r_state == S_FETCH) begin
                if (instr_valid) begin
                    r_ir  <= instr;
                    r_cnt <= '0;
                end else if (r_cnt != CNT_LAST) begin
                    r_cnt <= r_cnt + 8'd1;
                end
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        fetch_req    = 1'b0;
        exec_en      = 1'b0;
        pc_load      = 1'b0;
        pc_inc       = 1'b0;
        fault        = 1'b0;
        halted       = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_next_state = S_FETCH;
            end
            S_FETCH: begin
                fetch_req = 1'b1;
                if (instr_valid) begin
                    w_next_state = S_EXEC;
                end else if (r_cnt == CNT_LAST) begin
                    w_next_state = S_FAULT;
                end
            end
            S_EXEC: begin
                if (!stall) begin
                    exec_en = 1'b1;
`ifdef PC_SEQ_HALT_DETECT_EN
                    if (w_self_jump) begin
                        w_next_state = S_HALT;
                    end else begin
                        pc_load      = w_taken;
                        pc_inc       = ~w_taken;
                        w_next_state = S_FETCH;
                    end
`else
                    pc_load      = w_taken;
                    pc_inc       = ~w_taken;
                    w_next_state = S_FETCH;
`endif
                end
            end
            S_FAULT: begin
                fault = 1'b1;
            end
`ifdef PC_SEQ_HALT_DETECT_EN
            S_HALT: begin
                halted = 1'b1;
            end
`endif
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    assign ir        = r_ir;
    assign pc_in     = a_val;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_pc_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pc_sequencer
//
// Directed self-checking bench for pc_sequencer (WIDTH=16,
// TIMEOUT_CYCLES=64). Inputs change 1 time unit after a rising edge;
// outputs are checked at the falling edge or shortly after the rising edge.
// Honours PC_SEQ_HALT_DETECT_EN for the self-jump scenario.
// ---------------------------------------------------------------------------
module tb_pc_sequencer;

  logic        clk;
  logic        reset;
  logic [15:0] instr;
  logic        instr_valid;
  logic        zr;
  logic        ng;
  logic [15:0] a_val;
  logic [15:0] pc_out;
  logic        stall;
  logic        fetch_req;
  logic [15:0] ir;
  logic        exec_en;
  logic        pc_load;
  logic        pc_inc;
  logic [15:0] pc_in;
  logic        fault;
  logic        halted;
  logic [2:0]  dbg_state;

  int n_tests;
  int n_fail;

  pc_sequencer #(.WIDTH(16), .TIMEOUT_CYCLES(64)) dut (
    .clk         (clk),
    .reset       (reset),
    .instr       (instr),
    .instr_valid (instr_valid),
    .zr          (zr),
    .ng          (ng),
    .a_val       (a_val),
    .pc_out      (pc_out),
    .stall       (stall),
    .fetch_req   (fetch_req),
    .ir          (ir),
    .exec_en     (exec_en),
    .pc_load     (pc_load),
    .pc_inc      (pc_inc),
    .pc_in       (pc_in),
    .fault       (fault),
    .halted      (halted),
    .dbg_state   (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one word for a single cycle; returns 1 unit after the edge that
  // moves the sequencer into EXEC.
  task automatic fetch_one(input logic [15:0] w);
    instr       = w;
    instr_valid = 1'b1;
    step();
    instr_valid = 1'b0;
  endtask

  // Returns inside the first FETCH cycle after reset release.
  task automatic do_reset();
    reset       = 1'b0;
    instr_valid = 1'b0;
    stall       = 1'b0;
    zr          = 1'b0;
    ng          = 1'b0;
    repeat (2) step();
    @(negedge clk);
    reset = 1'b1;
    step();
  endtask

  // scenarios
  task automatic test_reset();
    reset = 1'b0; instr = 16'h0; instr_valid = 1'b0; zr = 1'b0; ng = 1'b0;
    a_val = 16'h0; pc_out = 16'h0; stall = 1'b0;
    repeat (3) step();
    @(negedge clk);
    n_tests++;
    if ({fetch_req, exec_en, pc_load, pc_inc, fault, halted} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_strobes: got %b expected 000000",
               {fetch_req, exec_en, pc_load, pc_inc, fault, halted});
    end
    n_tests++;
    if (ir !== 16'h0) begin
      n_fail++; $display("FAIL reset_ir: got %h expected 0000", ir);
    end
    n_tests++;
    if (dbg_state !== 3'd0) begin
      n_fail++; $display("FAIL reset_state: got %0d expected 0", dbg_state);
    end
    reset = 1'b1;
    #1;
    n_tests++;
    if (fetch_req !== 1'b0) begin
      n_fail++; $display("FAIL idle_after_release: fetch_req got %b expected 0", fetch_req);
    end
    step();
    n_tests++;
    if (fetch_req !== 1'b1) begin
      n_fail++; $display("FAIL first_fetch: fetch_req got %b expected 1", fetch_req);
    end
  endtask

  task automatic test_a_instr();
    instr = 16'h0005; instr_valid = 1'b1; stall = 1'b0;
    @(negedge clk);
    n_tests++;
    if (fetch_req !== 1'b1) begin
      n_fail++; $display("FAIL a_fetch_req: got %b expected 1", fetch_req);
    end
    step();
    instr_valid = 1'b0;
    @(negedge clk);
    n_tests++;
    if (ir !== 16'h0005) begin
      n_fail++; $display("FAIL a_ir: got %h expected 0005", ir);
    end
    n_tests++;
    if ({fetch_req, exec_en, pc_load, pc_inc} !== 4'b0101) begin
      n_fail++;
      $display("FAIL a_exec: req/en/load/inc got %b expected 0101",
               {fetch_req, exec_en, pc_load, pc_inc});
    end
    step();
    #1;
    n_tests++;
    if ({fetch_req, exec_en} !== 2'b10) begin
      n_fail++; $display("FAIL a_refetch: req/en got %b expected 10", {fetch_req, exec_en});
    end
  endtask

  task automatic test_jump();
    logic [15:0] t_instr [9] = '{16'hE302, 16'hE302, 16'hE304, 16'hE301, 16'hE301,
                                 16'hE305, 16'hE305, 16'h0007, 16'hE300};
    logic        t_zr    [9] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    logic        t_ng    [9] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    logic        t_load  [9] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [15:0] t_a     [9] = '{16'h0010, 16'h0010, 16'h0123, 16'h7FFF, 16'h0042,
                                 16'hABCD, 16'h0001, 16'h5555, 16'h0900};
    pc_out = 16'h1234;
    for (int i = 0; i < 9; i++) begin
      zr = t_zr[i]; ng = t_ng[i]; a_val = t_a[i];
      fetch_one(t_instr[i]);
      @(negedge clk);
      n_tests++;
      if ({exec_en, pc_load, pc_inc} !== {1'b1, t_load[i], ~t_load[i]}) begin
        n_fail++;
        $display("FAIL jump_%0d (ir=%h zr=%b ng=%b): en/load/inc got %b expected %b",
                 i, t_instr[i], t_zr[i], t_ng[i], {exec_en, pc_load, pc_inc},
                 {1'b1, t_load[i], ~t_load[i]});
      end
      n_tests++;
      if (pc_in !== t_a[i]) begin
        n_fail++; $display("FAIL jump_pc_in_%0d: got %h expected %h", i, pc_in, t_a[i]);
      end
      step();
      #1;
      n_tests++;
      if (fetch_req !== 1'b1) begin
        n_fail++; $display("FAIL jump_refetch_%0d: fetch_req got %b expected 1", i, fetch_req);
      end
    end
    zr = 1'b0; ng = 1'b0;
  endtask

  task automatic test_stall();
    int pulses = 0;
    int bad = 0;
    stall = 1'b1;
    fetch_one(16'h0003);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (exec_en) pulses++;
      if ({fetch_req, exec_en, pc_load, pc_inc} !== 4'b0 || ir !== 16'h0003) bad++;
      step();
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++; $display("FAIL stall_hold: got %0d bad cycles expected 0", bad);
    end
    stall = 1'b0;
    @(negedge clk);
    if (exec_en) pulses++;
    n_tests++;
    if ({exec_en, pc_load, pc_inc} !== 3'b101) begin
      n_fail++; $display("FAIL stall_release: en/load/inc got %b expected 101",
                         {exec_en, pc_load, pc_inc});
    end
    step();
    #1;
    if (exec_en) pulses++;
    n_tests++;
    if (pulses != 1) begin
      n_fail++; $display("FAIL stall_pulses: got %0d expected 1", pulses);
    end
    n_tests++;
    if (fetch_req !== 1'b1) begin
      n_fail++; $display("FAIL stall_refetch: fetch_req got %b expected 1", fetch_req);
    end
  endtask

  task automatic test_back_to_back();
    int pulses = 0;
    int bad = 0;
    logic [15:0] word;
    instr_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      word  = 16'h0011 + 16'(i);
      instr = word;
      @(negedge clk);
      if (fetch_req !== 1'b1 || exec_en !== 1'b0) bad++;
      step();
      // valid stays high in EXEC with a different word; it must be ignored
      instr = 16'hFFFF;
      @(negedge clk);
      if (exec_en) pulses++;
      if (ir !== word || fetch_req !== 1'b0) bad++;
      step();
    end
    instr_valid = 1'b0;
    n_tests++;
    if (pulses != 3) begin
      n_fail++; $display("FAIL b2b_pulses: got %0d in 6 cycles expected 3", pulses);
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++; $display("FAIL b2b_sequence: got %0d bad samples expected 0", bad);
    end
  endtask

  task automatic test_self_jump();
    zr = 1'b0; ng = 1'b0;
    a_val = 16'h0020; pc_out = 16'h0021;
    fetch_one(16'hEA87);
    @(negedge clk);
    n_tests++;
    if ({exec_en, pc_load, pc_inc} !== 3'b110) begin
      n_fail++; $display("FAIL jmp_other: en/load/inc got %b expected 110",
                         {exec_en, pc_load, pc_inc});
    end
    step();
    pc_out = 16'h0020;
    fetch_one(16'hEA87);
    @(negedge clk);
`ifdef PC_SEQ_HALT_DETECT_EN
    n_tests++;
    if ({exec_en, pc_load, pc_inc} !== 3'b100) begin
      n_fail++; $display("FAIL self_jmp_commit: en/load/inc got %b expected 100",
                         {exec_en, pc_load, pc_inc});
    end
    step();
    instr_valid = 1'b1;
    repeat (3) step();
    n_tests++;
    if ({halted, fetch_req, exec_en, pc_load, pc_inc} !== 5'b10000) begin
      n_fail++; $display("FAIL self_jmp_halt: halt/req/en/load/inc got %b expected 10000",
                         {halted, fetch_req, exec_en, pc_load, pc_inc});
    end
    do_reset();
    n_tests++;
    if ({halted, fetch_req} !== 2'b01) begin
      n_fail++; $display("FAIL halt_cleared: halt/req got %b expected 01", {halted, fetch_req});
    end
`else
    n_tests++;
    if ({exec_en, pc_load, pc_inc, halted} !== 4'b1100) begin
      n_fail++; $display("FAIL self_jmp_exec: en/load/inc/halt got %b expected 1100",
                         {exec_en, pc_load, pc_inc, halted});
    end
    step();
    #1;
    n_tests++;
    if ({fetch_req, halted} !== 2'b10) begin
      n_fail++; $display("FAIL self_jmp_loop: req/halt got %b expected 10", {fetch_req, halted});
    end
`endif
  endtask

  task automatic test_timeout();
    int bad = 0;
    instr_valid = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (fetch_req !== 1'b1 || fault !== 1'b0) bad++;
      step();
    end
    // a completed fetch must restart the timeout count
    fetch_one(16'h0001);
    step();
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (fetch_req !== 1'b1 || fault !== 1'b0) bad++;
      step();
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++; $display("FAIL timeout_wait: got %0d bad cycles expected 0", bad);
    end
    @(negedge clk);
    n_tests++;
    if ({fault, fetch_req, exec_en, pc_load, pc_inc} !== 5'b10000) begin
      n_fail++; $display("FAIL timeout_fault: fault/req/en/load/inc got %b expected 10000",
                         {fault, fetch_req, exec_en, pc_load, pc_inc});
    end
    instr = 16'hBEEF; instr_valid = 1'b1;
    repeat (3) step();
    n_tests++;
    if (fault !== 1'b1 || ir !== 16'h0001) begin
      n_fail++; $display("FAIL fault_sticky: fault got %b ir got %h expected 1 0001", fault, ir);
    end
    instr_valid = 1'b0;
    reset = 1'b0;
    #1;
    n_tests++;
    if (fault !== 1'b0) begin
      n_fail++; $display("FAIL fault_clear: got %b expected 0", fault);
    end
    do_reset();
  endtask

  task automatic test_async_reset();
    int pulses = 0;
    zr = 1'b0; ng = 1'b0; stall = 1'b0; a_val = 16'h0000; pc_out = 16'h0100;
    fetch_one(16'h8007);
    #1;
    n_tests++;
    if ({exec_en, pc_load} !== 2'b11) begin
      n_fail++; $display("FAIL arst_pre: en/load got %b expected 11", {exec_en, pc_load});
    end
    reset = 1'b0;
    #1;
    n_tests++;
    if ({fetch_req, exec_en, pc_load, pc_inc, fault, halted, ir, pc_in} !== 38'b0) begin
      n_fail++;
      $display("FAIL arst_outputs: req/en/load/inc/fault/halt=%b ir=%h pc_in=%h expected all 0",
               {fetch_req, exec_en, pc_load, pc_inc, fault, halted}, ir, pc_in);
    end
    @(negedge clk);
    if (exec_en) pulses++;
    @(negedge clk);
    reset = 1'b1;
    #1;
    if (exec_en) pulses++;
    n_tests++;
    if (fetch_req !== 1'b0 || dbg_state !== 3'd0) begin
      n_fail++; $display("FAIL arst_idle: fetch_req got %b state %0d expected 0 0",
                         fetch_req, dbg_state);
    end
    step();
    if (exec_en) pulses++;
    n_tests++;
    if (fetch_req !== 1'b1) begin
      n_fail++; $display("FAIL arst_fetch: fetch_req got %b expected 1", fetch_req);
    end
    n_tests++;
    if (pulses != 0) begin
      n_fail++; $display("FAIL arst_no_strobe: got %0d exec pulses expected 0", pulses);
    end
  endtask

  // sequence + final report
  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_a_instr();
    test_jump();
    test_stall();
    test_back_to_back();
    test_self_jump();
    test_timeout();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
